// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed 7-segment scan driver:
//   - active-low segment patterns (seg[0] = a .. seg[6] = g) for the digits
//     0-9, plus the blank and dash patterns
//   - slot-index type (one slot per display digit, 7 = leftmost)
//   - snapshot record captured once per frame
//   - divider counter width helper
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_D0 = 7'h40;
    localparam logic [6:0] SEG_D1 = 7'h79;
    localparam logic [6:0] SEG_D2 = 7'h24;
    localparam logic [6:0] SEG_D3 = 7'h30;
    localparam logic [6:0] SEG_D4 = 7'h19;
    localparam logic [6:0] SEG_D5 = 7'h12;
    localparam logic [6:0] SEG_D6 = 7'h02;
    localparam logic [6:0] SEG_D7 = 7'h78;
    localparam logic [6:0] SEG_D8 = 7'h00;
    localparam logic [6:0] SEG_D9 = 7'h10;

    typedef logic [2:0] slot_t;

    localparam slot_t SLOT_FIRST = 3'd7;
    localparam slot_t SLOT_LAST  = 3'd0;

    // Everything the display shows during one frame. dig[7] is hrL,
    // dig[0] is milC, so a slot index selects its digit directly.
    typedef struct packed {
        logic             fmt;
        logic             ampm;
        logic             edit;
        logic [7:0][3:0]  dig;
    } snap_t;

    // Width of a counter that must hold 0..div-1 (never narrower than 1 bit).
    function automatic int div_width(input int div);
        if (div <= 2) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to 7-segment decoder, active-low outputs.
// Codes 10-15 are not valid BCD and show a dash (segment g only).
// Ports:
//   bcd  in  4  BCD digit
//   seg  out 7  segment pattern, seg[0] = a .. seg[6] = g, 0 = lit
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Drives an 8-digit common-anode multiplexed 7-segment display from the BCD
// digits of the 12/24-hour clock core. One digit is lit per scan slot; the
// slot walks from the leftmost digit (7) down to 0 and wraps. All inputs are
// snapshotted once per frame so a frame never mixes old and new time.
// Decimal points separate HH.MM.SS; the slot-0 point marks PM in 12-hour mode.
//
// Optional build macro EDIT_BLINK_EN: while the snapshotted edit flag is set,
// the HH:MM digits (slots 7..4) blink at BLINK_HZ. Without the macro the edit
// input is only carried in the snapshot.
//
// Parameters:
//   CLK_HZ    input clock frequency
//   SCAN_HZ   scan slots per second (a frame is 8 slots)
//   BLINK_HZ  edit-blink rate (one full visible+hidden period per 1/BLINK_HZ)
// Ports:
//   clk                 in   1  system clock
//   rst                 in   1  synchronous reset, active-high
//   fmt                 in   1  1 = 12-hour, 0 = 24-hour
//   ampm                in   1  0 = AM, 1 = PM
//   edit                in   1  clock core is in edit mode
//   hrL..milC           in   4  BCD digits, left to right
//   an                  out  8  anode enables, active-low, an[7] = hrL
//   seg                 out  7  segments a..g = seg[0]..seg[6], active-low
//   dp                  out  1  decimal point, active-low
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       fmt,
    input  logic       ampm,
    input  logic       edit,
    input  logic [3:0] hrL,
    input  logic [3:0] hrR,
    input  logic [3:0] mL,
    input  logic [3:0] mR,
    input  logic [3:0] sL,
    input  logic [3:0] sR,
    input  logic [3:0] milL,
    input  logic [3:0] milC,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int SCAN_W   = div_width(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg7_scan_driver: CLK_HZ/SCAN_HZ must be at least 2");
    end

    if (BLINK_HZ < 1) begin : g_bad_blink_hz
        $error("seg7_scan_driver: BLINK_HZ must be at least 1");
    end

    // ---- stage 0: scan prescaler and slot counter ----
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tick;
    slot_t             slot_idx;
    logic              frame_wrap;

    assign scan_tick  = (scan_cnt == SCAN_LAST);
    assign frame_wrap = scan_tick && (slot_idx == SLOT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // slot_idx is the slot presented on the next tick; it wraps 0 -> 7
    // naturally through the 3-bit decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_idx <= SLOT_FIRST;
        end else if (scan_tick) begin
            slot_idx <= slot_idx - slot_t'(1);
        end
    end

    // ---- stage 0: frame snapshot ----
    snap_t snap;
    snap_t live;
    logic  load_p0;

    assign live = {fmt, ampm, edit, hrL, hrR, mL, mR, sL, sR, milL, milC};

    // load_p0 marks the first cycle after reset so the opening frame shows
    // current inputs rather than the cleared snapshot. The wrap tick presents
    // slot 0 from the old snapshot and loads the new one in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap    <= '0;
            load_p0 <= 1'b1;
        end else begin
            load_p0 <= 1'b0;
            if (load_p0 || frame_wrap) begin
                snap <= live;
            end
        end
    end

    // ---- stage 0: edit blink ----
    logic blank_hi;

`ifdef EDIT_BLINK_EN
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int BLINK_W   = div_width(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("seg7_scan_driver: CLK_HZ/(2*BLINK_HZ) must be at least 1");
    end

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_hidden;

    // Held in the visible phase with the prescaler cleared whenever edit is
    // low, so entering edit mode always begins with a full visible window.
    always_ff @(posedge clk) begin
        if (rst || !edit) begin
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt    <= '0;
            blink_hidden <= ~blink_hidden;
        end else begin
            blink_cnt    <= blink_cnt + BLINK_W'(1);
        end
    end

    assign blank_hi = snap.edit && blink_hidden;
`else
    logic edit_unused;

    assign edit_unused = snap.edit;
    assign blank_hi    = 1'b0;
`endif

    // ---- stage 0 -> 1: decode and output register ----
    logic [3:0] cur_digit;
    logic [6:0] cur_pat;
    logic [7:0] nxt_an;
    logic [6:0] nxt_seg;
    logic       nxt_dp;

    assign cur_digit = snap.dig[slot_idx];

    seg7_decode u_decode (
        .bcd (cur_digit),
        .seg (cur_pat)
    );

    always_comb begin
        nxt_an  = ~(8'b1 << slot_idx);
        nxt_seg = cur_pat;
        nxt_dp  = 1'b1;
        case (slot_idx)
            3'd6, 3'd4: nxt_dp = 1'b0;
            3'd0:       nxt_dp = ~(snap.fmt & snap.ampm);
            default:    nxt_dp = 1'b1;
        endcase
        // slots 7..4 are the HH:MM digits
        if (blank_hi && slot_idx[2]) begin
            nxt_seg = SEG_BLANK;
            nxt_dp  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (scan_tick) begin
            an  <= nxt_an;
            seg <= nxt_seg;
            dp  <= nxt_dp;
        end
    end

endmodule
